// File: rtl/cpu_seq_pkg.sv
// Shared state encoding and constants for the multi-cycle CPU sequencer.
package cpu_seq_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned INSTR_BYTES = 4;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_IRQ_VECTOR   = 32'h0000_0040;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter shared by the fetch and data-memory handshakes.
// o_tc_c flags the last cycle a request may remain unacknowledged.
module bus_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at terminal count; the sequencer leaves the wait state there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc_c) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc_c = (r_cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle CPU sequencer: PC, instruction latch and req/ack memory handshakes.
// Define CPU_SEQ_IRQ_EN to add the level-sensitive interrupt entry (irq/irq_ack/epc).
module cpu_seq_ctrl
    import cpu_seq_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           ADDR_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEF_RESET_VECTOR),
    parameter int unsigned           MAX_WAIT     = 15
`ifdef CPU_SEQ_IRQ_EN
    ,
    parameter logic [DATA_WIDTH-1:0] IRQ_VECTOR   = DATA_WIDTH'(DEF_IRQ_VECTOR)
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic                  dmem_ack,
    input  logic                  dec_is_load,
    input  logic                  dec_is_store,
    input  logic                  dec_is_jump,
    input  logic                  dec_is_branch,
    input  logic                  dec_is_halt,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] jump_target,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] ir,
    output logic [DATA_WIDTH-1:0] pc,
    output logic                  mdr_load,
    output logic                  reg_write,
    output logic [STATE_W-1:0]    state,
    output logic                  halted,
    output logic                  bus_error
`ifdef CPU_SEQ_IRQ_EN
    ,
    input  logic                  irq,
    output logic                  irq_ack,
    output logic [DATA_WIDTH-1:0] epc
`endif
);

    localparam logic [DATA_WIDTH-1:0] RST_PC = {RESET_VECTOR[DATA_WIDTH-1:2], 2'b00};

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pc, w_pc_nxt;
    logic [DATA_WIDTH-1:0] r_ir, w_ir_nxt;
    logic                  r_bus_error, w_bus_error_nxt;
    logic                  r_imem_req, r_dmem_req, r_dmem_we, r_reg_write, r_halted;
    logic [ADDR_WIDTH-1:0] r_dmem_addr;
    logic                  w_mdr_load;
    logic                  w_req, w_ack, w_tc;
    logic                  w_unused;

    // Counter runs only while a request is outstanding; any ack or idle state clears it.
    assign w_req = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_ack = ((r_state == ST_FETCH) && imem_ack) || ((r_state == ST_MEM) && dmem_ack);

    bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk    (clk),
        .rst_n  (reset_n),
        .i_clr  (!w_req || w_ack),
        .i_en   (w_req && !w_ack),
        .o_tc_c (w_tc)
    );

`ifdef CPU_SEQ_IRQ_EN
    localparam logic [DATA_WIDTH-1:0] IRQ_PC = {IRQ_VECTOR[DATA_WIDTH-1:2], 2'b00};
    logic                  r_irq_ack, w_irq_take;
    logic [DATA_WIDTH-1:0] r_epc, w_epc_nxt;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_ir_nxt        = r_ir;
        w_bus_error_nxt = r_bus_error;
        w_mdr_load      = 1'b0;
`ifdef CPU_SEQ_IRQ_EN
        w_irq_take      = 1'b0;
        w_epc_nxt       = r_epc;
`endif
        case (r_state)
            ST_BOOT: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    w_ir_nxt    = imem_rdata;
                    w_state_nxt = ST_DECODE;
                end else if (w_tc) begin
                    w_state_nxt     = ST_ERROR;
                    w_bus_error_nxt = 1'b1;
                end
            end
            ST_DECODE: begin
                w_pc_nxt    = r_pc + DATA_WIDTH'(INSTR_BYTES);
                w_state_nxt = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (dec_is_halt) begin
                    w_state_nxt = ST_HALT;
                end else if (dec_is_jump) begin
                    w_pc_nxt    = {jump_target[DATA_WIDTH-1:2], 2'b00};
                    w_state_nxt = ST_FETCH;
                end else if (dec_is_branch) begin
                    if (branch_taken) begin
                        w_pc_nxt = {branch_target[DATA_WIDTH-1:2], 2'b00};
                    end
                    w_state_nxt = ST_FETCH;
                end else if (dec_is_load || dec_is_store) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (r_dmem_we) begin
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_mdr_load  = 1'b1;
                        w_state_nxt = ST_WB;
                    end
                end else if (w_tc) begin
                    w_state_nxt     = ST_ERROR;
                    w_bus_error_nxt = 1'b1;
                end
            end
            ST_WB:    w_state_nxt = ST_FETCH;
            ST_HALT:  w_state_nxt = ST_HALT;
            ST_ERROR: w_state_nxt = ST_ERROR;
            default:  w_state_nxt = ST_ERROR;
        endcase
`ifdef CPU_SEQ_IRQ_EN
        // Interrupt redirects the next fetch; epc keeps the PC that would have been fetched.
        if (irq && ((r_state == ST_HALT) ||
                    ((w_state_nxt == ST_FETCH) &&
                     ((r_state == ST_EXECUTE) || (r_state == ST_MEM) || (r_state == ST_WB))))) begin
            w_irq_take  = 1'b1;
            w_epc_nxt   = w_pc_nxt;
            w_pc_nxt    = IRQ_PC;
            w_state_nxt = ST_FETCH;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RST_PC;
            r_ir        <= '0;
            r_bus_error <= 1'b0;
            r_imem_req  <= 1'b0;
            r_dmem_req  <= 1'b0;
            r_dmem_we   <= 1'b0;
            r_dmem_addr <= '0;
            r_reg_write <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_ir        <= w_ir_nxt;
            r_bus_error <= w_bus_error_nxt;
            r_imem_req  <= (w_state_nxt == ST_FETCH);
            r_dmem_req  <= (w_state_nxt == ST_MEM);
            r_reg_write <= (w_state_nxt == ST_WB);
            r_halted    <= (w_state_nxt == ST_HALT);
            // Data address and direction are frozen for the whole access.
            if (w_state_nxt != ST_MEM) begin
                r_dmem_we <= 1'b0;
            end else if (r_state == ST_EXECUTE) begin
                r_dmem_we   <= dec_is_store;
                r_dmem_addr <= mem_addr[ADDR_WIDTH+1:2];
            end
        end
    end

`ifdef CPU_SEQ_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_ack <= 1'b0;
            r_epc     <= '0;
        end else begin
            r_irq_ack <= w_irq_take;
            r_epc     <= w_epc_nxt;
        end
    end

    assign irq_ack = r_irq_ack;
    assign epc     = r_epc;
`endif

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc[ADDR_WIDTH+1:2];
    assign dmem_req  = r_dmem_req;
    assign dmem_we   = r_dmem_we;
    assign dmem_addr = r_dmem_addr;
    assign ir        = r_ir;
    assign pc        = r_pc;
    assign mdr_load  = w_mdr_load;
    assign reg_write = r_reg_write;
    assign state     = r_state;
    assign halted    = r_halted;
    assign bus_error = r_bus_error;

    assign w_unused = ^{mem_addr[DATA_WIDTH-1:ADDR_WIDTH+2], mem_addr[1:0],
                        jump_target[1:0], branch_target[1:0]};

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed self-checking bench for cpu_seq_ctrl; define CPU_SEQ_IRQ_EN to include the IRQ scenario.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req, imem_ack;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [7:0]  dmem_addr;
    logic        dec_is_load, dec_is_store, dec_is_jump, dec_is_branch, dec_is_halt;
    logic        branch_taken;
    logic [31:0] jump_target, branch_target, mem_addr;
    logic [31:0] ir, pc;
    logic        mdr_load, reg_write, halted, bus_error;
    logic [2:0]  state;
`ifdef CPU_SEQ_IRQ_EN
    logic        irq, irq_ack;
    logic [31:0] epc;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_seq_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_VECTOR(32'h0), .MAX_WAIT(15)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
        .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .dec_is_jump(dec_is_jump),
        .dec_is_branch(dec_is_branch), .dec_is_halt(dec_is_halt), .branch_taken(branch_taken),
        .jump_target(jump_target), .branch_target(branch_target), .mem_addr(mem_addr),
        .ir(ir), .pc(pc), .mdr_load(mdr_load), .reg_write(reg_write),
        .state(state), .halted(halted), .bus_error(bus_error)
`ifdef CPU_SEQ_IRQ_EN
        , .irq(irq), .irq_ack(irq_ack), .epc(epc)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 0; imem_rdata = '0; dmem_ack = 0;
        dec_is_load = 0; dec_is_store = 0; dec_is_jump = 0; dec_is_branch = 0; dec_is_halt = 0;
        branch_taken = 0; jump_target = '0; branch_target = '0; mem_addr = '0;
`ifdef CPU_SEQ_IRQ_EN
        irq = 0;
`endif
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    // Fetch one instruction with immediate ack and stop in EXECUTE (pc = 4).
    task automatic go_execute();
        do_reset();
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick();
        tick();
        imem_ack = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({state, pc, ir} !== {3'd0, 32'h0, 32'h0}) begin
            n_err++; $display("FAIL reset_regs: state=%0d pc=%h ir=%h want 0/0/0", state, pc, ir);
        end
        n_vec++;
        if ({imem_req, dmem_req, mdr_load, reg_write, halted, bus_error} !== 6'b0) begin
            n_err++; $display("FAIL reset_outs: got %b want 000000",
                              {imem_req, dmem_req, mdr_load, reg_write, halted, bus_error});
        end
    endtask

    task automatic test_alu();
        int unsigned exp_st [8];
        int unsigned exp_pc [8];
        bit          exp_rw [8];
        exp_st = '{1, 2, 3, 5, 1, 2, 3, 5};
        exp_pc = '{0, 0, 4, 4, 4, 4, 8, 8};
        exp_rw = '{0, 0, 0, 1, 0, 0, 0, 1};
        do_reset();
        imem_ack = 1; imem_rdata = 32'hA0A0_0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (state !== 3'(exp_st[i]) || pc !== exp_pc[i] || reg_write !== exp_rw[i]) begin
                n_err++; $display("FAIL alu_seq[%0d]: state=%0d pc=%h rw=%b want %0d/%h/%b",
                                  i, state, pc, reg_write, exp_st[i], exp_pc[i], exp_rw[i]);
            end
        end
        n_vec++;
        if (ir !== 32'hA0A0_0001) begin
            n_err++; $display("FAIL alu_ir: got %h want a0a00001", ir);
        end
    endtask

    task automatic test_fetch_wait();
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) begin
            imem_rdata = 32'hDEAD_0000 + 32'(i);
            imem_ack   = (i == 3);
            n_vec++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || ir !== 32'h0 || state !== 3'd1) begin
                n_err++; $display("FAIL fetch_wait[%0d]: req=%b addr=%h ir=%h state=%0d want 1/00/0/1",
                                  i, imem_req, imem_addr, ir, state);
            end
            tick();
        end
        imem_ack = 0;
        n_vec++;
        if (state !== 3'd2 || ir !== 32'hDEAD_0003 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL fetch_capture: state=%0d ir=%h req=%b want 2/dead0003/0",
                              state, ir, imem_req);
        end
    endtask

    task automatic test_load_store();
        go_execute();
        dec_is_load = 1; mem_addr = 32'h1C;
        tick();
        for (int i = 0; i < 3; i++) begin
            dmem_ack = (i == 2);
            #1;
            n_vec++;
            if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_addr !== 8'h07 || dmem_we !== 1'b0 ||
                mdr_load !== (i == 2)) begin
                n_err++; $display("FAIL load_mem[%0d]: state=%0d req=%b addr=%h we=%b mdr=%b want 4/1/07/0/%0d",
                                  i, state, dmem_req, dmem_addr, dmem_we, mdr_load, i == 2);
            end
            tick();
        end
        dmem_ack = 0; dec_is_load = 0;
        n_vec++;
        if (state !== 3'd5 || reg_write !== 1'b1 || mdr_load !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++; $display("FAIL load_wb: state=%0d rw=%b mdr=%b req=%b want 5/1/0/0",
                              state, reg_write, mdr_load, dmem_req);
        end
        go_execute();
        dec_is_store = 1; mem_addr = 32'h40;
        tick();
        dmem_ack = 1;
        #1;
        n_vec++;
        if (dmem_we !== 1'b1 || dmem_addr !== 8'h10 || mdr_load !== 1'b0) begin
            n_err++; $display("FAIL store_mem: we=%b addr=%h mdr=%b want 1/10/0", dmem_we, dmem_addr, mdr_load);
        end
        tick();
        n_vec++;
        if (state !== 3'd1 || reg_write !== 1'b0 || dmem_req !== 1'b0) begin
            n_err++; $display("FAIL store_done: state=%0d rw=%b req=%b want 1/0/0", state, reg_write, dmem_req);
        end
    endtask

    task automatic test_branch_jump();
        go_execute();
        dec_is_branch = 1; branch_taken = 1; branch_target = 32'h23;
        tick();
        n_vec++;
        if (state !== 3'd1 || pc !== 32'h20 || imem_addr !== 8'h08) begin
            n_err++; $display("FAIL br_taken: state=%0d pc=%h addr=%h want 1/20/08", state, pc, imem_addr);
        end
        go_execute();
        dec_is_branch = 1; branch_taken = 0; branch_target = 32'h23;
        tick();
        n_vec++;
        if (state !== 3'd1 || pc !== 32'h4) begin
            n_err++; $display("FAIL br_not_taken: state=%0d pc=%h want 1/4", state, pc);
        end
        go_execute();
        dec_is_jump = 1; jump_target = 32'h80;
        tick();
        n_vec++;
        if (state !== 3'd1 || pc !== 32'h80 || imem_addr !== 8'h20) begin
            n_err++; $display("FAIL jump: state=%0d pc=%h addr=%h want 1/80/20", state, pc, imem_addr);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        tick();
        for (int i = 0; i < 15; i++) begin
            n_vec++;
            if (state !== 3'd1 || imem_req !== 1'b1) begin
                n_err++; $display("FAIL timeout_wait[%0d]: state=%0d req=%b want 1/1", i, state, imem_req);
            end
            tick();
        end
        n_vec++;
        if (state !== 3'd7 || bus_error !== 1'b1 || imem_req !== 1'b0) begin
            n_err++; $display("FAIL timeout_err: state=%0d err=%b req=%b want 7/1/0", state, bus_error, imem_req);
        end
        imem_ack = 1; dmem_ack = 1;
        repeat (3) tick();
        n_vec++;
        if (state !== 3'd7 || imem_req !== 1'b0 || dmem_req !== 1'b0 || bus_error !== 1'b1) begin
            n_err++; $display("FAIL error_absorb: state=%0d ireq=%b dreq=%b err=%b want 7/0/0/1",
                              state, imem_req, dmem_req, bus_error);
        end
        do_reset();
        tick();
        repeat (14) tick();
        imem_ack = 1;
        tick();
        imem_ack = 0;
        n_vec++;
        if (state !== 3'd2 || bus_error !== 1'b0) begin
            n_err++; $display("FAIL ack_at_limit: state=%0d err=%b want 2/0", state, bus_error);
        end
    endtask

    task automatic test_halt_reset();
        go_execute();
        dec_is_halt = 1;
        tick();
        dec_is_halt = 0;
        imem_ack = 1;
        repeat (2) tick();
        n_vec++;
        if (state !== 3'd6 || halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h4) begin
            n_err++; $display("FAIL halt: state=%0d halted=%b req=%b pc=%h want 6/1/0/4",
                              state, halted, imem_req, pc);
        end
        #2 reset_n = 0;
        #1;
        n_vec++;
        if (pc !== 32'h0 || state !== 3'd0 || halted !== 1'b0) begin
            n_err++; $display("FAIL async_reset: pc=%h state=%0d halted=%b want 0/0/0", pc, state, halted);
        end
        reset_n = 1;
    endtask

`ifdef CPU_SEQ_IRQ_EN
    task automatic test_irq();
        go_execute();
        dec_is_halt = 1;
        tick();
        dec_is_halt = 0;
        irq = 1;
        tick();
        irq = 0;
        n_vec++;
        if (state !== 3'd1 || pc !== 32'h40 || irq_ack !== 1'b1 || epc !== 32'h4) begin
            n_err++; $display("FAIL irq_halt: state=%0d pc=%h ack=%b epc=%h want 1/40/1/4",
                              state, pc, irq_ack, epc);
        end
        tick();
        n_vec++;
        if (irq_ack !== 1'b0) begin
            n_err++; $display("FAIL irq_ack_pulse: got %b want 0", irq_ack);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0;
        clear_inputs();
        test_reset();
        test_alu();
        test_fetch_wait();
        test_load_store();
        test_branch_jump();
        test_timeout();
        test_halt_reset();
`ifdef CPU_SEQ_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer for the CPU core.
- Owns the PC, the instruction latch and the cycle state machine (fetch/decode/execute/mem/writeback).
- Replaces fixed single-cycle memory timing with req/ack handshakes to external ROM/RAM, a wait-state timeout and halt/error states.
- Sits between the external memories and the datapath (ALU, register file, MDR).

Parameters:
- DATA_WIDTH, 32, width of instruction word, PC and target/address inputs.
- ADDR_WIDTH, 8, word-address width presented to ROM/RAM.
- RESET_VECTOR, 0, byte address loaded into PC on reset.
- MAX_WAIT, 15, max cycles a req may stay unacknowledged before ERROR (1..255).
- IRQ_VECTOR, 32'h40, byte address taken on interrupt (optional feature only).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_WIDTH  pc[ADDR_WIDTH+1:2].
- imem_ack  in  1  ROM data valid.
- imem_rdata  in  DATA_WIDTH  ROM data.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load, valid only with dmem_req.
- dmem_addr  out  ADDR_WIDTH  mem_addr[ADDR_WIDTH+1:2].
- dmem_ack  in  1  RAM access complete / read data valid.
- dec_is_load, dec_is_store, dec_is_jump, dec_is_branch, dec_is_halt  in  1 each  decoder flags from ir, mutually exclusive.
- branch_taken  in  1  branch condition from flags.
- jump_target, branch_target, mem_addr  in  DATA_WIDTH  byte addresses computed by datapath.
- ir  out  DATA_WIDTH  latched instruction.
- pc  out  DATA_WIDTH  current PC.
- mdr_load  out  1  one-cycle pulse capturing RAM read data.
- reg_write  out  1  one-cycle register-file write pulse.
- state  out  3  current state encoding.
- halted  out  1  state == HALT.
- bus_error  out  1  sticky timeout flag.

Behaviour:
- States: BOOT=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5, HALT=6, ERROR=7.
- Reset (async): state=BOOT, pc=RESET_VECTOR, ir=0, wait counter=0, bus_error=0. All req/pulse outputs 0.
- BOOT -> FETCH after exactly one cycle.
- Requests are Moore outputs:
  - imem_req = (state==FETCH).
  - dmem_req = (state==MEM).
  - Address is stable while the req is high.
  - An ack with no req is ignored.
- FETCH: on the cycle imem_ack=1, ir <= imem_rdata and state -> DECODE. Minimum latency: ack in the first FETCH cycle.
- DECODE: pc <= pc+4 (wraps modulo 2^DATA_WIDTH); -> EXECUTE.
- EXECUTE priority: halt -> HALT; jump -> pc<=jump_target, FETCH; branch -> if branch_taken pc<=branch_target, FETCH; load/store -> MEM; else -> WB.
- Every loaded PC has bits [1:0] forced to 0.
- MEM: dmem_we = dec_is_store. On dmem_ack:
  - load: mdr_load=1 in that same cycle, -> WB.
  - store: -> FETCH.
- WB: reg_write=1 for exactly one cycle; -> FETCH.
- Timeout:
  - Counter clears on entry to FETCH/MEM and increments each cycle the req is unacknowledged.
  - If the count reaches MAX_WAIT -> ERROR and bus_error=1.
  - An ack in the same cycle as the terminal count wins (normal transition).
- HALT and ERROR are absorbing, with no requests; only reset exits (except IRQ below).
- Reset mid-transaction drops req asynchronously; memories must tolerate abandoned requests.
- State, pc and ir are only ever changed by clk edges or reset.

Optional Feature:
- Macro: CPU_SEQ_IRQ_EN.
- With it defined:
  - Adds ports irq (in 1), irq_ack (out 1) and epc (out DATA_WIDTH, reset 0).
  - On any transition into FETCH from EXECUTE/MEM/WB, or while in HALT, with irq=1: epc <= pc (pc already the next sequential or target value), pc <= IRQ_VECTOR, irq_ack=1 for one cycle, state -> FETCH.
  - irq is level-sensitive, with no masking or nesting.
- Without it: those ports are absent and HALT exits only by reset.

Decomposition:
- Package cpu_seq_pkg holds:
  - state enum and its 3-bit width;
  - INSTR_BYTES=4;
  - default vectors.
- One natural sub-module: bus_wait_timer (clear/enable/terminal-count counter, width clog2(MAX_WAIT+1)), instantiated once and shared by FETCH and MEM.

Test Plan:
- Reset release, imem_ack tied high, ALU-type instructions -> state sequence 0,1,2,3,5,1…; pc 0->4->8; reg_write one cycle per instruction.
- Fetch with ack delayed 3 cycles -> imem_req high for 4 cycles, imem_addr constant, ir captures data only on the ack cycle.
- Load at mem_addr=0x1C with dmem_ack after 2 cycles -> dmem_addr=7, dmem_we=0, mdr_load pulse coincident with ack, then reg_write next cycle.
- Taken branch branch_target=0x23 -> pc=0x20. Not-taken -> pc=pc+4. Jump to 0x80 -> imem_addr=0x20.
- No ack for MAX_WAIT=15 cycles -> state=7, bus_error=1, no further requests. Ack exactly on cycle 15 -> no error.
- Halt instruction -> halted=1. Assert reset_n=0 mid-halt -> pc=RESET_VECTOR immediately. With CPU_SEQ_IRQ_EN: irq in HALT -> pc=IRQ_VECTOR, irq_ack pulse, epc holds the halt's pc+4.
